// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the CPU-side memories.
package imem_loader_pkg;

    localparam int unsigned IMEM_ADDR_W    = 16;
    localparam int unsigned IMEM_DATA_W    = 32;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word_valid is asserted combinationally on the last byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          word_valid,
    output logic [8*BYTES_PER_WORD-1:0]   word
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]                idx;
    logic [8*BYTES_PER_WORD-9:0]     low;
    logic                            last;

    assign last       = (idx == IDX_W'(BYTES_PER_WORD - 1));
    assign word_valid = in_valid && last && !clear;
    assign word       = {in_data, low};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            low <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (in_valid) begin
            if (!last) begin
                low[8*idx +: 8] <= in_data;
            end
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a word-count header, packs bytes into words and writes them to
// instruction memory from address 0, holding the CPU until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam int unsigned HDR_IDX_W = $clog2(HDR_BYTES);
    localparam logic [16:0] DEPTH_X   = 17'(DEPTH);

    state_t                  state, state_next;
    logic [HDR_IDX_W-1:0]    hdr_idx;
    logic [15:0]             count;
    logic [15:0]             hdr_full;
    logic                    we_q;
    logic                    accept;
    logic                    final_wr;
    logic                    pk_valid;
    logic [8*BYTES_PER_WORD-1:0] pk_word;

    assign accept   = s_valid && s_ready;
    assign hdr_full = {s_data, count[7:0]};
    // The final write cycle still sits in DATA; no further byte belongs to this image.
    assign final_wr = we_q && ((17'(words_loaded) + 17'd1) == {1'b0, count});
    assign mem_we   = we_q && !start;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .in_valid   ((state == ST_DATA) && accept),
        .in_data    (s_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_hold   = 1'b1;
        unique case (state)
            ST_IDLE: ;
            ST_LEN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (accept && (hdr_idx == HDR_IDX_W'(HDR_BYTES - 1))) begin
                    if (hdr_full == '0) begin
                        state_next = ST_DONE;
                    end else if ({1'b0, hdr_full} > DEPTH_X) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                s_ready = !final_wr;
                busy    = 1'b1;
                if (final_wr) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        if (start) begin
            state_next = ST_LEN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_idx      <= '0;
            count        <= '0;
            we_q         <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else if (start) begin
            hdr_idx      <= '0;
            count        <= '0;
            we_q         <= 1'b0;
            words_loaded <= '0;
        end else begin
            we_q <= pk_valid;
            if (pk_valid) begin
                mem_addr  <= words_loaded;
                mem_wdata <= DATA_W'(pk_word);
            end
            if (mem_we) begin
                words_loaded <= words_loaded + ADDR_W'(1);
            end
            if ((state == ST_LEN) && accept) begin
                count[8*hdr_idx +: 8] <= s_data;
                hdr_idx               <= hdr_idx + HDR_IDX_W'(1);
            end
        end
    end

endmodule
